// File: rtl/vip_color_pkg.sv
// Shared constants and state encoding for the VIP colour-space converters.
// Holds both the RGB->YCbCr (forward) and YCbCr->RGB (inverse) Q8 coefficients.
package vip_color_pkg;

    localparam int PROD_W = 17;
    localparam int SUM_W  = 19;

    // Inverse (YCbCr -> RGB) Q8 coefficients
    localparam logic signed [PROD_W-1:0] C_R_CR = 17'sd359;
    localparam logic signed [PROD_W-1:0] C_G_CB = 17'sd88;
    localparam logic signed [PROD_W-1:0] C_G_CR = 17'sd183;
    localparam logic signed [PROD_W-1:0] C_B_CB = 17'sd454;
    localparam logic signed [8:0]        C_OFFSET = 9'sd128;
    localparam logic signed [SUM_W-1:0]  C_ROUND  = 19'sd128;

    // Forward (RGB -> YCbCr) Q8 coefficients
    localparam int C_Y_R  = 77;
    localparam int C_Y_G  = 150;
    localparam int C_Y_B  = 29;
    localparam int C_CB_R = 43;
    localparam int C_CB_G = 85;
    localparam int C_CB_B = 128;
    localparam int C_CR_R = 128;
    localparam int C_CR_G = 107;
    localparam int C_CR_B = 21;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_SUM  = 3'd2,
        ST_OUT  = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

endpackage

// File: rtl/vip_sat_u8.sv
// Takes a signed Q8 sum, drops the fraction (arithmetic shift by 8) and
// clamps the integer part into 0..255.
module vip_sat_u8
(
    input  logic signed [18:0] i_sum,
    output logic        [7:0]  o_u8
);

    // The fraction bits are discarded by the shift; rounding was already added upstream.
    logic w_unused_frac;
    assign w_unused_frac = ^i_sum[7:0];

    always_comb begin
        o_u8 = i_sum[15:8];
        if (i_sum[18]) begin
            o_u8 = 8'h00;
        end else if (|i_sum[17:16]) begin
            o_u8 = 8'hFF;
        end
    end

endmodule

// File: rtl/vip_ycbcr_rgb888.sv
// Full-range BT.601 YCbCr 4:4:4 -> RGB888, Q8 fixed point, one pixel in flight.
//   state | meaning
//   IDLE  | waiting for start, captures d_in
//   MUL   | chroma products registered
//   SUM   | per-channel Q8 sums registered
//   OUT   | saturate, write d_out, pulse all_end
//   WAIT  | hold until start drops
module vip_ycbcr_rgb888
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_d_in,
    output logic        o_all_end,
    output logic [23:0] o_d_out
);
    import vip_color_pkg::*;

    state_t r_state;
    state_t w_state_nxt;

    logic w_cap;
    logic w_mul;
    logic w_sum;
    logic w_out;
    logic w_clr_end;

    logic        [7:0]       r_y;
    logic signed [8:0]       r_cb_s;
    logic signed [8:0]       r_cr_s;
    logic signed [PROD_W-1:0] r_pr;
    logic signed [PROD_W-1:0] r_pgb;
    logic signed [PROD_W-1:0] r_pgr;
    logic signed [PROD_W-1:0] r_pb;
    logic signed [SUM_W-1:0]  r_sr;
    logic signed [SUM_W-1:0]  r_sg;
    logic signed [SUM_W-1:0]  r_sb;
    logic signed [SUM_W-1:0]  w_y_q8;
    logic        [7:0]       w_r;
    logic        [7:0]       w_g;
    logic        [7:0]       w_b;
    logic        [23:0]      r_d_out;
    logic                    r_all_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start)  w_state_nxt = ST_MUL;
            ST_MUL:  if (i_start)  w_state_nxt = ST_SUM;
            ST_SUM:  if (i_start)  w_state_nxt = ST_OUT;
            ST_OUT:  if (i_start)  w_state_nxt = ST_WAIT;
            ST_WAIT: if (!i_start) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // start low in MUL/SUM/OUT simply withholds the enables, which is the pause.
    always_comb begin
        w_cap     = 1'b0;
        w_mul     = 1'b0;
        w_sum     = 1'b0;
        w_out     = 1'b0;
        w_clr_end = 1'b0;
        case (r_state)
            ST_IDLE: w_cap     = i_start;
            ST_MUL:  w_mul     = i_start;
            ST_SUM:  w_sum     = i_start;
            ST_OUT:  w_out     = i_start;
            ST_WAIT: w_clr_end = 1'b1;
            default: ;
        endcase
    end

    assign w_y_q8 = $signed({3'b000, r_y, 8'h00});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y       <= '0;
            r_cb_s    <= '0;
            r_cr_s    <= '0;
            r_pr      <= '0;
            r_pgb     <= '0;
            r_pgr     <= '0;
            r_pb      <= '0;
            r_sr      <= '0;
            r_sg      <= '0;
            r_sb      <= '0;
            r_d_out   <= '0;
            r_all_end <= 1'b0;
        end else begin
            if (w_cap) begin
                r_y    <= i_d_in[23:16];
                r_cb_s <= $signed({1'b0, i_d_in[15:8]}) - C_OFFSET;
                r_cr_s <= $signed({1'b0, i_d_in[7:0]}) - C_OFFSET;
            end
            if (w_mul) begin
                r_pr  <= PROD_W'(r_cr_s) * C_R_CR;
                r_pgb <= PROD_W'(r_cb_s) * C_G_CB;
                r_pgr <= PROD_W'(r_cr_s) * C_G_CR;
                r_pb  <= PROD_W'(r_cb_s) * C_B_CB;
            end
            if (w_sum) begin
                r_sr <= w_y_q8 + SUM_W'(r_pr) + C_ROUND;
                r_sg <= w_y_q8 - SUM_W'(r_pgb) - SUM_W'(r_pgr) + C_ROUND;
                r_sb <= w_y_q8 + SUM_W'(r_pb) + C_ROUND;
            end
            if (w_out) begin
                r_d_out   <= {w_r, w_g, w_b};
                r_all_end <= 1'b1;
            end else if (w_clr_end) begin
                r_all_end <= 1'b0;
            end
        end
    end

    vip_sat_u8 u_sat_r (.i_sum(r_sr), .o_u8(w_r));
    vip_sat_u8 u_sat_g (.i_sum(r_sg), .o_u8(w_g));
    vip_sat_u8 u_sat_b (.i_sum(r_sb), .o_u8(w_b));

    assign o_d_out   = r_d_out;
    assign o_all_end = r_all_end;

endmodule

// File: tb/tb_vip_ycbcr_rgb888.sv
// Directed-vector bench for vip_ycbcr_rgb888; expected pixels are hand-computed
// from the Q8 BT.601 inverse equations.
module tb_vip_ycbcr_rgb888;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] d_in;
    logic        all_end;
    logic [23:0] d_out;

    int vectors;
    int miscompares;

    vip_ycbcr_rgb888 dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_d_in    (d_in),
        .o_all_end (all_end),
        .o_d_out   (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one uninterrupted transaction starting at the current negedge.
    // lat = edges from capture to all_end (-1 on timeout); the cycle after
    // all_end is also returned so callers can check the pulse width and hold.
    task automatic do_pixel(input logic [23:0] d, output int lat,
                            output logic [23:0] dout, output logic end_after,
                            output logic [23:0] dout_after);
        start = 1'b1;
        d_in  = d;
        lat   = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            d_in = ~d;
            if (all_end === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        dout  = d_out;
        start = 1'b0;
        @(negedge clk);
        end_after  = all_end;
        dout_after = d_out;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        d_in  = 24'h123456;
        repeat (3) @(negedge clk);
        vectors++;
        if (d_out !== 24'h000000) begin
            miscompares++;
            $display("FAIL reset_d_out got=%h want=%h", d_out, 24'h000000);
        end
        vectors++;
        if (all_end !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_all_end got=%b want=0", all_end);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pixels(input string name, input logic [23:0] d, input logic [23:0] exp);
        int          lat;
        logic [23:0] dout;
        logic        end_after;
        logic [23:0] dout_after;
        do_pixel(d, lat, dout, end_after, dout_after);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL %s_latency got=%0d want=3", name, lat);
        end
        vectors++;
        if (dout !== exp) begin
            miscompares++;
            $display("FAIL %s_d_out got=%h want=%h", name, dout, exp);
        end
        vectors++;
        if (end_after !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_pulse_width all_end_next=%b want=0", name, end_after);
        end
        vectors++;
        if (dout_after !== exp) begin
            miscompares++;
            $display("FAIL %s_hold got=%h want=%h", name, dout_after, exp);
        end
    endtask

    task automatic test_primary;
        test_pixels("grey",  24'h808080, 24'h808080);
        test_pixels("white", 24'hFF8080, 24'hFFFFFF);
        test_pixels("black", 24'h008080, 24'h000000);
    endtask

    task automatic test_high_sat;
        test_pixels("red",     24'h4C55FF, 24'hFE0000);
        test_pixels("r_clamp", 24'hFF00FF, 24'hFFD01C);
    endtask

    task automatic test_low_sat;
        test_pixels("low_clamp", 24'h000000, 24'h008800);
    endtask

    // Previous output is 24'h008800 from test_low_sat.
    task automatic test_pause;
        int n;
        int lat;
        start = 1'b1;
        d_in  = 24'h4C55FF;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            d_in = 24'h00FF00 + 24'(p);
            @(negedge clk);
            vectors++;
            if (all_end !== 1'b0 || d_out !== 24'h008800) begin
                miscompares++;
                $display("FAIL pause_hold%0d all_end=%b d_out=%h want 0/%h", p, all_end, d_out, 24'h008800);
            end
        end
        start = 1'b1;
        lat = -1;
        n = 5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (all_end === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        vectors++;
        if (lat !== 6) begin
            miscompares++;
            $display("FAIL pause_latency got=%0d want=6", lat);
        end
        vectors++;
        if (d_out !== 24'hFE0000) begin
            miscompares++;
            $display("FAIL pause_d_out got=%h want=%h", d_out, 24'hFE0000);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_held_start;
        int pulses;
        pulses = 0;
        start = 1'b1;
        d_in  = 24'h808080;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d_in = 24'hFF00FF ^ 24'(i);
            if (all_end === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL held_pulses got=%0d want=1", pulses);
        end
        vectors++;
        if (d_out !== 24'h808080) begin
            miscompares++;
            $display("FAIL held_d_out got=%h want=%h", d_out, 24'h808080);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (d_out !== 24'h808080 || all_end !== 1'b0) begin
            miscompares++;
            $display("FAIL held_release d_out=%h all_end=%b want %h/0", d_out, all_end, 24'h808080);
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        d_in  = 24'hFF00FF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (d_out !== 24'h000000) begin
            miscompares++;
            $display("FAIL rstmid_d_out got=%h want=%h", d_out, 24'h000000);
        end
        vectors++;
        if (all_end !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_all_end got=%b want=0", all_end);
        end
        rst = 1'b0;
        test_pixels("after_rst", 24'hFF8080, 24'hFFFFFF);
    endtask

    task automatic test_back_to_back;
        test_pixels("b2b_a", 24'h000000, 24'h008800);
        test_pixels("b2b_b", 24'h808080, 24'h808080);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        d_in  = '0;
        @(negedge clk);
        test_reset;
        test_primary;
        test_high_sat;
        test_low_sat;
        test_pause;
        test_held_start;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vip_ycbcr_rgb888.md
# vip_ycbcr_rgb888

Converts one packed full-range BT.601 YCbCr 4:4:4 pixel back to RGB888 using Q8 fixed-point arithmetic with rounding and 0..255 saturation. It is the inverse of the VIP RGB888→YCbCr converter and uses the same transaction-level start/all_end handshake. It sits on the output side of the VIP chain and restores RGB for display or frame-buffer write-back after processing in the YCbCr domain.

## Interface
- No parameters; coefficients are fixed constants, see Structure.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request; a transaction begins when sampled high in IDLE.
- d_in  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}, unsigned 8-bit each, sampled only on the IDLE→MUL edge.
- all_end  out  1  completion strobe, high for exactly one cycle per transaction.
- d_out  out  24  {R[23:16], G[15:8], B[7:0]}; valid from the all_end cycle and held until the next transaction's OUT edge.

## Operation
- States: IDLE, MUL, SUM, OUT, WAIT.
- **IDLE**, start=1:
  - latch y = Y;
  - cb_s = Cb−128 and cr_s = Cr−128, signed 9-bit;
  - go to MUL.
- **MUL** (start=1): register signed 17-bit products:
  - pr = 359·cr_s
  - pgb = 88·cb_s
  - pgr = 183·cr_s
  - pb = 454·cb_s
  - Go to SUM.
- **SUM** (start=1): form signed 19-bit sums:
  - sr = (y<<8) + pr + 128
  - sg = (y<<8) − pgb − pgr + 128
  - sb = (y<<8) + pb + 128
  - Go to OUT.
- **OUT** (start=1):
  - each channel = sum>>>8 (arithmetic), clamped: <0 → 0, >255 → 255;
  - write d_out, set all_end=1;
  - go to WAIT.
- **WAIT**:
  - all_end←0 on the first edge;
  - stay in WAIT while start=1;
  - go to IDLE on the first edge with start=0.
  - A start held high never starts a second transaction; start must drop for ≥1 cycle.
- **start=0 in MUL/SUM/OUT:** pause. State and all internal registers hold, d_out and all_end are unchanged, and the block resumes from the same state when start returns to 1. d_in is ignored during a pause.
- **Reset:** rst=1 has priority over everything.
  - State goes to IDLE; all internal registers, d_out and all_end go to 0.
  - A reset mid-transaction discards it without asserting all_end.
  - If start=1 on the first edge after rst falls, a new transaction captures d_in on that edge.
- **Arithmetic:** rounding is add-half-then-truncate (floor of x+0.5). No intermediate overflow is possible at the stated widths. Maximum |sum| < 2^18.

## Timing
- Reset values: d_out=24'h000000, all_end=0, state=IDLE.
- Let edge k be the edge where start=1 is sampled in IDLE.
- Products are registered at k+1, sums at k+2, d_out and all_end=1 at k+3.
- all_end is high for the cycle after k+3 only and falls at k+4.
- Uninterrupted latency: 3 edges from capture to valid output.
- Each pause cycle adds one cycle of latency.
- Minimum transaction spacing: 5 cycles (capture, 3 pipeline edges, start low in WAIT).
- Not pipelined across pixels: one pixel in flight.

## Structure
- Shared package/include vip_color_pkg, holding:
  - coefficient constants: 359, 88, 183, 454, offset 128, round 128;
  - state encoding (3-bit, IDLE=0 … WAIT=4);
  - product width 17 and sum width 19.
  - The forward converter's constants (77/150/29, 43/85/128, 128/107/21) also move here.
- Sub-module vip_sat_u8: combinational signed 19-bit → clamped unsigned 8-bit after >>>8, instantiated three times in OUT.

## Test plan
- **Primary colours.** Reset, then d_in=24'h808080 → d_out 24'h808080; 24'hFF8080 → 24'hFFFFFF; 24'h008080 → 24'h000000. all_end is one cycle each, 3 edges after capture.
- **Red and high saturation.**
  - d_in=24'h4C55FF (Y=76, Cb=85, Cr=255) → d_out 24'hFE0000.
  - d_in=24'hFF00FF → d_out 24'hFFD01C (R clamped high).
- **Low saturation.** d_in=24'h000000 → d_out 24'h008800 (R and B clamped to 0).
- **Pause and held start.**
  - start drops for 3 cycles while in SUM → all_end is delayed by exactly 3 cycles, with the value unchanged.
  - start held high for 20 cycles → exactly one all_end pulse; d_in changes during the hold are ignored.
- **Reset mid-transaction.**
  - rst pulsed in SUM → d_out=0, all_end=0, and no all_end pulse for the aborted pixel.
  - With start still high, the next transaction starts on the first edge after rst falls and completes normally.
